uart_tx_pkt_arbiter: RTL



---
 rtl/uart_tx_pkt_arbiter_if.sv | 29 ++
 rtl/uart_tx_pkt_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_pkt_arbiter_if.sv
// Bundle of the packet-request, per-source payload stream and framed UART byte stream
// used by uart_tx_pkt_arbiter; the arbiter connects through the master modport.
interface uart_tx_pkt_arbiter_if #(
  parameter int NUM_REQ = 2
);
  // Every channel is valid/ready: a beat transfers on a rising edge where both are high;
  // the sender holds data stable until then, and ready may depend combinationally on valid.
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*8-1:0]  req_type;
  logic [NUM_REQ*16-1:0] req_len;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*8-1:0]  s_tdata;
  logic [NUM_REQ-1:0]    s_tvalid;
  logic [NUM_REQ-1:0]    s_tlast;
  logic [NUM_REQ-1:0]    s_tready;
  logic [7:0]            m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;

  modport master (
    input  req_valid, req_type, req_len, s_tdata, s_tvalid, s_tlast, m_tready,
    output req_ready, s_tready, m_tdata, m_tvalid
  );

  modport slave (
    output req_valid, req_type, req_len, s_tdata, s_tvalid, s_tlast, m_tready,
    input  req_ready, s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/uart_tx_pkt_arbiter.sv
// Round-robin packet arbiter framing each granted packet (SOF, type, len, payload, CRC)
// onto one UART TX byte stream. Define UART_TX_CRC_EN for a real CRC-16/CCITT-FALSE.
module uart_tx_pkt_arbiter #(
  parameter int         NUM_REQ  = 2,
  parameter logic [7:0] SOF_BYTE = 8'h5A,
  localparam int        GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_tx_pkt_arbiter_if.master   bus,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
  output logic                    err_len,
  output logic [3:0]              state_dbg
);

  typedef enum logic [3:0] {
    IDLE, SOF, TYPE, LEN_HI, LEN_LO, PAYLOAD, PAD, CRC_HI, CRC_LO, DRAIN
  } state_t;

  state_t         state, state_n;
  logic [GW-1:0]  grant_q, last_grant, winner;
  logic [7:0]     type_q;
  logic [15:0]    len_q, len_m1, cnt;
  logic           drain_q, found, xfer;
  logic [15:0]    crc_q;
  int             arb_idx;

  assign len_m1    = len_q - 16'd1;
  assign xfer      = bus.m_tvalid && bus.m_tready;
  assign busy      = (state != IDLE);
  assign grant_id  = grant_q;
  assign state_dbg = state;

  always_comb begin
    state_n       = state;
    bus.req_ready = '0;
    bus.s_tready  = '0;
    bus.m_tdata   = 8'h00;
    bus.m_tvalid  = 1'b0;
    err_len       = 1'b0;
    found         = 1'b0;
    winner        = grant_q;
    arb_idx       = 0;
    // Search begins one past the last winner so every source gets a turn.
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = (int'(last_grant) + 1 + k) % NUM_REQ;
      if (!found && bus.req_valid[arb_idx]) begin
        found  = 1'b1;
        winner = GW'(arb_idx);
      end
    end
    if (!rst) begin
      case (state)
        IDLE: if (found) begin
          bus.req_ready[winner] = 1'b1;
          state_n = SOF;
        end
        SOF: begin
          bus.m_tvalid = 1'b1;
          bus.m_tdata  = SOF_BYTE;
          if (bus.m_tready) state_n = TYPE;
        end
        TYPE: begin
          bus.m_tvalid = 1'b1;
          bus.m_tdata  = type_q;
          if (bus.m_tready) state_n = LEN_HI;
        end
        LEN_HI: begin
          bus.m_tvalid = 1'b1;
          bus.m_tdata  = len_q[15:8];
          if (bus.m_tready) state_n = LEN_LO;
        end
        LEN_LO: begin
          bus.m_tvalid = 1'b1;
          bus.m_tdata  = len_q[7:0];
          if (bus.m_tready) state_n = (len_q == 16'd0) ? CRC_HI : PAYLOAD;
        end
        PAYLOAD: begin
          bus.m_tvalid           = bus.s_tvalid[grant_q];
          bus.m_tdata            = bus.s_tdata[8*grant_q +: 8];
          bus.s_tready[grant_q]  = bus.m_tready;
          if (bus.s_tvalid[grant_q] && bus.m_tready) begin
            if (bus.s_tlast[grant_q]) begin
              if (cnt == len_m1) state_n = CRC_HI;
              else begin
                err_len = 1'b1;
                state_n = PAD;
              end
            end else if (cnt == len_m1) begin
              err_len = 1'b1;
              state_n = CRC_HI;
            end
          end
        end
        PAD: begin
          bus.m_tvalid = 1'b1;
          if (bus.m_tready && cnt == len_m1) state_n = CRC_HI;
        end
        CRC_HI: begin
          bus.m_tvalid = 1'b1;
          bus.m_tdata  = crc_q[15:8];
          if (bus.m_tready) state_n = CRC_LO;
        end
        CRC_LO: begin
          bus.m_tvalid = 1'b1;
          bus.m_tdata  = crc_q[7:0];
          if (bus.m_tready) state_n = drain_q ? DRAIN : IDLE;
        end
        DRAIN: begin
          bus.s_tready[grant_q] = 1'b1;
          if (bus.s_tvalid[grant_q] && bus.s_tlast[grant_q]) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      type_q     <= 8'h00;
      len_q      <= 16'd0;
      cnt        <= 16'd0;
      drain_q    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (found) begin
          grant_q    <= winner;
          last_grant <= winner;
          type_q     <= bus.req_type[8*winner +: 8];
          len_q      <= bus.req_len[16*winner +: 16];
          cnt        <= 16'd0;
          drain_q    <= 1'b0;
        end
        PAYLOAD: if (xfer) begin
          cnt <= cnt + 16'd1;
          // Final counted byte without tlast: the rest of the stream is dropped after CRC.
          if (!bus.s_tlast[grant_q] && cnt == len_m1) drain_q <= 1'b1;
        end
        PAD: if (xfer) cnt <= cnt + 16'd1;
        default: ;
      endcase
    end
  end

`ifdef UART_TX_CRC_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) crc_q <= 16'hFFFF;
    else if (xfer && (state inside {TYPE, LEN_HI, LEN_LO, PAYLOAD, PAD}))
      crc_q <= crc16_byte(crc_q, bus.m_tdata);
  end
`else
  assign crc_q = 16'h0000;
`endif

endmodule
